wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 53 +++++
 rtl/wb_arbiter.sv | 102 ++++++++++
 tb/tb_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Bundles the write-back arbiter's bus signals.
// The two request ports, issue, hazard query, flush and the register-file
// write port are grouped here. The arbiter connects through the slave modport.
interface wb_arbiter_if;
    // Execute write-back request (port A)
    logic        i_AValid;
    logic [4:0]  i_ARd;
    logic [31:0] i_AData;
    logic        o_AReady;
    // Load write-back request (port B)
    logic        i_BValid;
    logic [4:0]  i_BRd;
    logic [31:0] i_BData;
    logic        o_BReady;
    // Issued instruction that will write Rd
    logic        i_IssueValid;
    logic [4:0]  i_IssueRd;
    // Hazard query
    logic [4:0]  i_Rnum1;
    logic [4:0]  i_Rnum2;
    logic        o_Busy1;
    logic        o_Busy2;
    // Clears all pending-write state
    logic        i_Flush;
    // Register-file write port
    logic        o_Wen;
    logic [4:0]  o_Wnum;
    logic [31:0] o_Wd;

    modport slave (
        input  i_AValid, i_ARd, i_AData,
        output o_AReady,
        input  i_BValid, i_BRd, i_BData,
        output o_BReady,
        input  i_IssueValid, i_IssueRd,
        input  i_Rnum1, i_Rnum2,
        output o_Busy1, o_Busy2,
        input  i_Flush,
        output o_Wen, o_Wnum, o_Wd
    );

    modport master (
        output i_AValid, i_ARd, i_AData,
        input  o_AReady,
        output i_BValid, i_BRd, i_BData,
        input  o_BReady,
        output i_IssueValid, i_IssueRd,
        output i_Rnum1, i_Rnum2,
        input  o_Busy1, o_Busy2,
        output i_Flush,
        input  o_Wen, o_Wnum, o_Wd
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter with a pending-write scoreboard.
// Two requesters (execute on A, load on B) share one register-file write port.
// The winner is captured at the accept edge and written one cycle later.
// A 32-entry pending scoreboard tracks issued-but-uncommitted destinations
// so that issue logic can query read-after-write hazards.
module wb_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input logic         i_clk,
    input logic         i_rst,
    wb_arbiter_if.slave bus
);

    logic        grant_a;
    logic        grant_b;
    logic        prio_b;
    logic [31:0] pending;
    logic [31:0] pending_next;

    // Grant selection: a lone requester always wins; ties go to A in fixed
    // mode, or to whichever port lost the previous acceptance in RR mode.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!i_rst) begin
            if (bus.i_AValid && bus.i_BValid) begin
                if (RR_EN && prio_b) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = 1'b1;
                end
            end else begin
                grant_a = bus.i_AValid;
                grant_b = bus.i_BValid;
            end
        end
    end

    assign bus.o_AReady = grant_a;
    assign bus.o_BReady = grant_b;

    // Round-robin pointer moves only when a request is actually accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prio_b <= 1'b0;
        end else if (grant_a) begin
            prio_b <= 1'b1;
        end else if (grant_b) begin
            prio_b <= 1'b0;
        end
    end

    // Register the winner for the write port; x0 writes are accepted but
    // never raise the write enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_Wen  <= 1'b0;
            bus.o_Wnum <= 5'd0;
            bus.o_Wd   <= 32'd0;
        end else begin
            bus.o_Wen <= 1'b0;
            if (grant_a) begin
                bus.o_Wnum <= bus.i_ARd;
                bus.o_Wd   <= bus.i_AData;
                bus.o_Wen  <= (bus.i_ARd != 5'd0);
            end else if (grant_b) begin
                bus.o_Wnum <= bus.i_BRd;
                bus.o_Wd   <= bus.i_BData;
                bus.o_Wen  <= (bus.i_BRd != 5'd0);
            end
        end
    end

    // Scoreboard update: the commit clears first so a same-cycle issue to
    // the same register re-sets it; flush wipes everything.
    always_comb begin
        pending_next = pending;
        if (bus.o_Wen) begin
            pending_next[bus.o_Wnum] = 1'b0;
        end
        if (bus.i_IssueValid && (bus.i_IssueRd != 5'd0)) begin
            pending_next[bus.i_IssueRd] = 1'b1;
        end
        if (bus.i_Flush) begin
            pending_next = 32'd0;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_next;
        end
    end

    assign bus.o_Busy1 = pending[bus.i_Rnum1];
    assign bus.o_Busy2 = pending[bus.i_Rnum2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios on a round-robin instance plus a
// fixed-priority instance. Expected grants and writes are queued by the
// stimulus and popped by a monitor whenever the DUT shows Ready or Wen.
module tb_wb_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rst;

    wb_arbiter_if rr_if ();
    wb_arbiter_if fp_if ();

    wb_arbiter #(.RR_EN(1'b1)) u_rr (.i_clk(clk), .i_rst(rst), .bus(rr_if.slave));
    wb_arbiter #(.RR_EN(1'b0)) u_fp (.i_clk(clk), .i_rst(rst), .bus(fp_if.slave));

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  grant_q[$];
    wr_t wr_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic exp_grant(input bit is_b);
        grant_q.push_back(is_b);
    endtask

    task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
        wr_t w;
        w.rd = rd;
        w.d  = d;
        wr_q.push_back(w);
    endtask

    // Monitor: pops an expected grant on every Ready and an expected write
    // on every Wen of the round-robin instance.
    initial begin
        bit  gb;
        wr_t w;
        forever begin
            @(negedge clk);
            if (rr_if.o_AReady || rr_if.o_BReady) begin
                check("ready_exclusive", 32'(rr_if.o_AReady && rr_if.o_BReady), 32'd0);
                check("ready_needs_valid",
                      32'((rr_if.o_AReady && !rr_if.i_AValid) || (rr_if.o_BReady && !rr_if.i_BValid)), 32'd0);
                if (grant_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_unexpected: got A=%0b B=%0b expected none at %0t",
                             rr_if.o_AReady, rr_if.o_BReady, $time);
                end else begin
                    gb = grant_q.pop_front();
                    check("grant_port_b", 32'(rr_if.o_BReady), 32'(gb));
                end
            end
            if (rr_if.o_Wen) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wen_unexpected: got Wnum=%0d Wd=%0h expected no write at %0t",
                             rr_if.o_Wnum, rr_if.o_Wd, $time);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_wnum", 32'(rr_if.o_Wnum), 32'(w.rd));
                    check("wr_wd", rr_if.o_Wd, w.d);
                end
            end
        end
    end

    task automatic clear_inputs();
        rr_if.i_AValid = 0; rr_if.i_ARd = 0; rr_if.i_AData = 0;
        rr_if.i_BValid = 0; rr_if.i_BRd = 0; rr_if.i_BData = 0;
        rr_if.i_IssueValid = 0; rr_if.i_IssueRd = 0;
        rr_if.i_Rnum1 = 0; rr_if.i_Rnum2 = 0; rr_if.i_Flush = 0;
        fp_if.i_AValid = 0; fp_if.i_ARd = 0; fp_if.i_AData = 0;
        fp_if.i_BValid = 0; fp_if.i_BRd = 0; fp_if.i_BData = 0;
        fp_if.i_IssueValid = 0; fp_if.i_IssueRd = 0;
        fp_if.i_Rnum1 = 0; fp_if.i_Rnum2 = 0; fp_if.i_Flush = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        // Reset with A requesting: no Ready, outputs cleared.
        rr_if.i_AValid = 1; rr_if.i_ARd = 5'd3; rr_if.i_AData = 32'h1;
        at_neg();
        check("rst_aready", 32'(rr_if.o_AReady), 32'd0);
        check("rst_bready", 32'(rr_if.o_BReady), 32'd0);
        step();
        rr_if.i_AValid = 0;
        rst = 1'b0;
        rr_if.i_Rnum1 = 5'd3;
        at_neg();
        check("rst_wen", 32'(rr_if.o_Wen), 32'd0);
        check("rst_wnum", 32'(rr_if.o_Wnum), 32'd0);
        check("rst_wd", rr_if.o_Wd, 32'd0);
        check("rst_busy1", 32'(rr_if.o_Busy1), 32'd0);
        step();

        // Single A request, one-cycle write latency.
        rr_if.i_AValid = 1; rr_if.i_ARd = 5'd5; rr_if.i_AData = 32'hDEADBEEF;
        exp_grant(1'b0); exp_wr(5'd5, 32'hDEADBEEF);
        at_neg();
        check("single_a_ready", 32'(rr_if.o_AReady), 32'd1);
        step();
        rr_if.i_AValid = 0;
        at_neg();
        check("wen_latency", 32'(rr_if.o_Wen), 32'd1);
        step();

        // Round-robin burst right after reset: A, B, A, B.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rr_if.i_AValid = 1; rr_if.i_ARd = 5'd1; rr_if.i_AData = 32'h100 + 32'(c);
            rr_if.i_BValid = 1; rr_if.i_BRd = 5'd2; rr_if.i_BData = 32'h200 + 32'(c);
            exp_grant(c[0]);
            if (c[0]) exp_wr(5'd2, 32'h200 + 32'(c));
            else      exp_wr(5'd1, 32'h100 + 32'(c));
            at_neg();
            if (c > 0) check("rr_wen_burst", 32'(rr_if.o_Wen), 32'd1);
            step();
        end
        rr_if.i_AValid = 0; rr_if.i_BValid = 0;
        at_neg();
        check("rr_wen_burst_last", 32'(rr_if.o_Wen), 32'd1);
        step();
        at_neg();
        check("rr_wen_burst_end", 32'(rr_if.o_Wen), 32'd0);
        step();

        // Fixed priority: A wins every tie.
        for (int c = 0; c < 3; c++) begin
            fp_if.i_AValid = 1; fp_if.i_ARd = 5'd10; fp_if.i_AData = 32'hA0 + 32'(c);
            fp_if.i_BValid = 1; fp_if.i_BRd = 5'd11; fp_if.i_BData = 32'hB0 + 32'(c);
            at_neg();
            check("fp_aready", 32'(fp_if.o_AReady), 32'd1);
            check("fp_bready", 32'(fp_if.o_BReady), 32'd0);
            step();
        end
        fp_if.i_AValid = 0; fp_if.i_BValid = 0;
        at_neg();
        check("fp_wen", 32'(fp_if.o_Wen), 32'd1);
        check("fp_wnum", 32'(fp_if.o_Wnum), 32'd10);
        check("fp_wd", fp_if.o_Wd, 32'hA2);
        step();

        // Issue Rd=7, query, then commit through A.
        rr_if.i_IssueValid = 1; rr_if.i_IssueRd = 5'd7; rr_if.i_Rnum1 = 5'd7;
        at_neg();
        check("busy_no_bypass", 32'(rr_if.o_Busy1), 32'd0);
        step();
        rr_if.i_IssueValid = 0;
        at_neg();
        check("busy_after_issue", 32'(rr_if.o_Busy1), 32'd1);
        step();
        rr_if.i_AValid = 1; rr_if.i_ARd = 5'd7; rr_if.i_AData = 32'h77;
        exp_grant(1'b0); exp_wr(5'd7, 32'h77);
        step();
        rr_if.i_AValid = 0;
        at_neg();
        check("busy_during_wen", 32'(rr_if.o_Busy1), 32'd1);
        step();
        at_neg();
        check("busy_after_commit", 32'(rr_if.o_Busy1), 32'd0);
        step();

        // Commit of Rd=9 coincides with a new issue of Rd=9: set wins.
        rr_if.i_AValid = 1; rr_if.i_ARd = 5'd9; rr_if.i_AData = 32'h99;
        exp_grant(1'b0); exp_wr(5'd9, 32'h99);
        step();
        rr_if.i_AValid = 0;
        rr_if.i_IssueValid = 1; rr_if.i_IssueRd = 5'd9; rr_if.i_Rnum2 = 5'd9;
        at_neg();
        check("collide_wen", 32'(rr_if.o_Wen), 32'd1);
        step();
        rr_if.i_IssueValid = 0;
        at_neg();
        check("set_wins", 32'(rr_if.o_Busy2), 32'd1);
        step();

        // B write to x0: accepted, no write enable.
        rr_if.i_BValid = 1; rr_if.i_BRd = 5'd0; rr_if.i_BData = 32'h55;
        exp_grant(1'b1);
        at_neg();
        check("x0_bready", 32'(rr_if.o_BReady), 32'd1);
        step();
        rr_if.i_BValid = 0;
        at_neg();
        check("x0_no_wen", 32'(rr_if.o_Wen), 32'd0);
        step();

        // Pending 3 and 4, then flush alongside an issue and an A write.
        rr_if.i_IssueValid = 1; rr_if.i_IssueRd = 5'd3;
        step();
        rr_if.i_IssueRd = 5'd4;
        step();
        rr_if.i_IssueValid = 0;
        rr_if.i_Rnum1 = 5'd3; rr_if.i_Rnum2 = 5'd4;
        at_neg();
        check("pend3_set", 32'(rr_if.o_Busy1), 32'd1);
        check("pend4_set", 32'(rr_if.o_Busy2), 32'd1);
        step();
        rr_if.i_Flush = 1;
        rr_if.i_IssueValid = 1; rr_if.i_IssueRd = 5'd5;
        rr_if.i_AValid = 1; rr_if.i_ARd = 5'd6; rr_if.i_AData = 32'h66;
        exp_grant(1'b0); exp_wr(5'd6, 32'h66);
        step();
        rr_if.i_Flush = 0; rr_if.i_IssueValid = 0; rr_if.i_AValid = 0;
        at_neg();
        check("flush_pend3", 32'(rr_if.o_Busy1), 32'd0);
        check("flush_pend4", 32'(rr_if.o_Busy2), 32'd0);
        check("flush_keeps_wen", 32'(rr_if.o_Wen), 32'd1);
        rr_if.i_Rnum1 = 5'd5; rr_if.i_Rnum2 = 5'd9;
        #1;
        check("flush_over_issue", 32'(rr_if.o_Busy1), 32'd0);
        check("flush_pend9", 32'(rr_if.o_Busy2), 32'd0);
        step();

        // Reset while A is requesting.
        rr_if.i_AValid = 1; rr_if.i_ARd = 5'd8; rr_if.i_AData = 32'h88;
        rst = 1'b1;
        at_neg();
        check("rst2_aready", 32'(rr_if.o_AReady), 32'd0);
        step();
        rst = 1'b0;
        rr_if.i_AValid = 0;
        at_neg();
        check("rst2_wen", 32'(rr_if.o_Wen), 32'd0);
        check("rst2_wnum", 32'(rr_if.o_Wnum), 32'd0);
        step();
        step();

        at_neg();
        check("grant_q_drained", 32'(grant_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
